// File: rtl/cpu_boot_loader.sv
// Byte-stream boot loader: parses A5-framed records into imem/dmem
// writes, verifies checksums and releases the downstream cpu on RUN.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_data      upstream byte stream
//   in_ready              loader accepts a byte this cycle
//   mem_we/mem_sel        write strobe, target (0 imem, 1 dmem)
//   mem_addr/mem_wdata    write address and data
//   cpu_rst               reset held on the downstream cpu
//   done                  RUN frame accepted, cpu released
//   err                   sticky frame error
module cpu_boot_loader (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic       mem_sel,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_rst,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    TYPE,
    ADDR,
    LEN,
    DATA,
    CSUM,
    RUN
  } state_t;

  state_t     state;
  state_t     state_n;

  logic       sel;
  logic       sel_n;
  logic [7:0] ptr;
  logic [7:0] ptr_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic [7:0] csum;
  logic [7:0] csum_n;
  logic       err_n;
  logic       we_n;
  logic       msel_n;
  logic [7:0] maddr_n;
  logic [7:0] mwd_n;
  logic       acc;

  assign acc = in_valid & in_ready;

  always_comb begin
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = cnt;
    csum_n  = csum;
    err_n   = err;
    we_n    = 1'b0;
    msel_n  = mem_sel;
    maddr_n = mem_addr;
    mwd_n   = mem_wdata;
    if (acc) begin
      unique case (state)
        IDLE: begin
          if (in_data == 8'hA5) state_n = TYPE;
        end
        TYPE: begin
          unique case (in_data)
            8'h00: begin
              sel_n   = 1'b0;
              state_n = ADDR;
            end
            8'h01: begin
              sel_n   = 1'b1;
              state_n = ADDR;
            end
            8'h02: begin
              state_n = err ? IDLE : RUN;
            end
            default: begin
              err_n   = 1'b1;
              state_n = IDLE;
            end
          endcase
        end
        ADDR: begin
          ptr_n   = in_data;
          state_n = LEN;
        end
        LEN: begin
          cnt_n   = in_data;
          csum_n  = 8'h00;
          state_n = (in_data == 8'h00) ? CSUM : DATA;
        end
        DATA: begin
          we_n    = 1'b1;
          msel_n  = sel;
          maddr_n = ptr;
          mwd_n   = in_data;
          ptr_n   = ptr + 8'd1;
          csum_n  = csum + in_data;
          cnt_n   = cnt - 8'd1;
          if (cnt == 8'd1) state_n = CSUM;
        end
        CSUM: begin
          if (in_data != csum) err_n = 1'b1;
          state_n = IDLE;
        end
        RUN: begin
          state_n = RUN;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Handshake and cpu control are registered from the next state so
  // they change on the same edge that accepts the RUN type byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 1'b0;
      ptr       <= 8'h00;
      cnt       <= 8'h00;
      csum      <= 8'h00;
      err       <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= 8'h00;
      mem_wdata <= 8'h00;
      in_ready  <= 1'b0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      csum      <= csum_n;
      err       <= err_n;
      mem_we    <= we_n;
      mem_sel   <= msel_n;
      mem_addr  <= maddr_n;
      mem_wdata <= mwd_n;
      in_ready  <= (state_n != RUN);
      cpu_rst   <= (state_n != RUN);
      done      <= (state_n == RUN);
    end
  end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Bench for cpu_boot_loader: directed frame vectors, a reset
// mid-frame sequence and random frames against a frame-level model.
module tb_cpu_boot_loader;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic       mem_sel;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rst;
  logic       done;
  logic       err;

  cpu_boot_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       ls[$];
  logic [7:0] la[$];
  logic [7:0] ld[$];

  always @(negedge clk) begin
    if (mem_we) begin
      ls.push_back(mem_sel);
      la.push_back(mem_addr);
      ld.push_back(mem_wdata);
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_log();
    ls.delete();
    la.delete();
    ld.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit bp);
    int guard;
    if (bp) begin
      int g;
      g = $urandom_range(0, 2);
      in_valid = 1'b0;
      repeat (g) begin
        in_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data = b;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: got ready=%0b want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string        name;
    int           n;
    logic [127:0] b;
    int           nw;
    logic         sel;
    logic [63:0]  wa;
    logic [63:0]  wd;
    bit           xerr;
    bit           xdone;
  } vec_t;

  vec_t v[6];

  logic       qs[$];
  logic [7:0] qa[$];
  logic [7:0] qd[$];

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;

    v[0].name = "load";
    v[0].n = 14;
    v[0].b = 128'({8'hA5, 8'h00, 8'h00, 8'h07,
                   8'h51, 8'h31, 8'h22, 8'h13,
                   8'h42, 8'h24, 8'hF0, 8'h0D,
                   8'hA5, 8'h02});
    v[0].nw = 7;
    v[0].sel = 1'b0;
    v[0].wa = 64'({8'h00, 8'h01, 8'h02, 8'h03,
                   8'h04, 8'h05, 8'h06});
    v[0].wd = 64'({8'h51, 8'h31, 8'h22, 8'h13,
                   8'h42, 8'h24, 8'hF0});
    v[0].xerr = 1'b0;
    v[0].xdone = 1'b1;

    v[1].name = "wrap";
    v[1].n = 7;
    v[1].b = 128'({8'hA5, 8'h01, 8'hFF, 8'h02,
                   8'h03, 8'h0A, 8'h0D});
    v[1].nw = 2;
    v[1].sel = 1'b1;
    v[1].wa = 64'({8'hFF, 8'h00});
    v[1].wd = 64'({8'h03, 8'h0A});
    v[1].xerr = 1'b0;
    v[1].xdone = 1'b0;

    v[2].name = "badsum";
    v[2].n = 8;
    v[2].b = 128'({8'hA5, 8'h00, 8'h10, 8'h01,
                   8'hAA, 8'h00, 8'hA5, 8'h02});
    v[2].nw = 1;
    v[2].sel = 1'b0;
    v[2].wa = 64'({8'h10});
    v[2].wd = 64'({8'hAA});
    v[2].xerr = 1'b1;
    v[2].xdone = 1'b0;

    v[3].name = "resync0";
    v[3].n = 9;
    v[3].b = 128'({8'h00, 8'h13, 8'hA5, 8'h00,
                   8'h20, 8'h00, 8'h00, 8'hA5,
                   8'h02});
    v[3].nw = 0;
    v[3].sel = 1'b0;
    v[3].wa = 64'h0;
    v[3].wd = 64'h0;
    v[3].xerr = 1'b0;
    v[3].xdone = 1'b1;

    v[4].name = "badtype";
    v[4].n = 2;
    v[4].b = 128'({8'hA5, 8'h07});
    v[4].nw = 0;
    v[4].sel = 1'b0;
    v[4].wa = 64'h0;
    v[4].wd = 64'h0;
    v[4].xerr = 1'b1;
    v[4].xdone = 1'b0;

    v[5].name = "badtype_then_load";
    v[5].n = 8;
    v[5].b = 128'({8'hA5, 8'h07, 8'hA5, 8'h01,
                   8'h40, 8'h01, 8'h5A, 8'h5A});
    v[5].nw = 1;
    v[5].sel = 1'b1;
    v[5].wa = 64'({8'h40});
    v[5].wd = 64'({8'h5A});
    v[5].xerr = 1'b1;
    v[5].xdone = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_sel", 32'(mem_sel), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    for (int t = 0; t < 6; t++) begin
      int nw;
      do_reset();
      clear_log();
      for (int i = 0; i < v[t].n; i++)
        send(v[t].b[8*(v[t].n-1-i) +: 8], t[0]);
      idle(4);
      nw = v[t].nw;
      chk($sformatf("%s_nwrites", v[t].name), ls.size(), nw);
      if (ls.size() == nw) begin
        for (int j = 0; j < nw; j++) begin
          chk($sformatf("%s_sel%0d", v[t].name, j),
              32'(ls[j]), 32'(v[t].sel));
          chk($sformatf("%s_addr%0d", v[t].name, j),
              32'(la[j]), 32'(v[t].wa[8*(nw-1-j) +: 8]));
          chk($sformatf("%s_data%0d", v[t].name, j),
              32'(ld[j]), 32'(v[t].wd[8*(nw-1-j) +: 8]));
        end
      end
      if (nw > 0)
        chk($sformatf("%s_addr_hold", v[t].name),
            32'(mem_addr), 32'(v[t].wa[7:0]));
      chk($sformatf("%s_err", v[t].name),
          32'(err), 32'(v[t].xerr));
      chk($sformatf("%s_done", v[t].name),
          32'(done), 32'(v[t].xdone));
      chk($sformatf("%s_cpu_rst", v[t].name),
          32'(cpu_rst), 32'(!v[t].xdone));
      chk($sformatf("%s_in_ready", v[t].name),
          32'(in_ready), 32'(!v[t].xdone));
    end

    do_reset();
    clear_log();
    for (int i = 0; i < 10; i++)
      send(v[0].b[8*(13-i) +: 8], 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    chk("midrst_cpu_rst", 32'(cpu_rst), 1);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_nwrites", ls.size(), 6);
    if (ls.size() == 6) begin
      for (int j = 0; j < 6; j++) begin
        chk($sformatf("midrst_addr%0d", j),
            32'(la[j]), j);
        chk($sformatf("midrst_data%0d", j),
            32'(ld[j]), 32'(v[0].wd[8*(6-j) +: 8]));
      end
    end
    clear_log();
    send(8'hF0, 1'b1);
    send(8'h0D, 1'b1);
    idle(3);
    chk("midrst_no_writes", ls.size(), 0);
    send(8'hA5, 1'b1);
    send(8'h00, 1'b1);
    send(8'h30, 1'b1);
    send(8'h01, 1'b1);
    send(8'h77, 1'b1);
    send(8'h77, 1'b1);
    idle(3);
    chk("midrst_new_nwrites", ls.size(), 1);
    if (ls.size() == 1) begin
      chk("midrst_new_addr", 32'(la[0]), 32'h30);
      chk("midrst_new_data", 32'(ld[0]), 32'h77);
    end
    chk("midrst_new_err", 32'(err), 0);

    begin
      bit xerr;
      do_reset();
      clear_log();
      xerr = 1'b0;
      for (int f = 0; f < 30; f++) begin
        int kind;
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          logic [7:0] g;
          g = 8'($urandom);
          if (g == 8'hA5) g = 8'h5A;
          send(g, 1'b1);
        end else if (kind == 1) begin
          logic [7:0] ty;
          ty = 8'($urandom_range(3, 255));
          send(8'hA5, 1'b1);
          send(ty, 1'b1);
          xerr = 1'b1;
        end else begin
          logic       s;
          logic [7:0] a;
          logic [7:0] d;
          logic [7:0] sum;
          int         len;
          s = 1'($urandom);
          a = 8'($urandom);
          len = $urandom_range(0, 6);
          sum = 8'h00;
          send(8'hA5, 1'b1);
          send({7'd0, s}, 1'b1);
          send(a, 1'b1);
          send(8'(len), 1'b1);
          for (int k = 0; k < len; k++) begin
            d = 8'($urandom);
            sum = 8'((int'(sum) + int'(d)) % 256);
            qs.push_back(s);
            qa.push_back(8'((int'(a) + k) % 256));
            qd.push_back(d);
            send(d, 1'b1);
          end
          if ($urandom_range(0, 6) == 0) begin
            sum = sum ^ 8'($urandom_range(1, 255));
            xerr = 1'b1;
          end
          send(sum, 1'b1);
        end
      end
      send(8'hA5, 1'b1);
      send(8'h02, 1'b1);
      idle(4);
      chk("rand_nwrites", ls.size(), qs.size());
      if (ls.size() == qs.size()) begin
        for (int j = 0; j < qs.size(); j++) begin
          chk($sformatf("rand_sel%0d", j),
              32'(ls[j]), 32'(qs[j]));
          chk($sformatf("rand_addr%0d", j),
              32'(la[j]), 32'(qa[j]));
          chk($sformatf("rand_data%0d", j),
              32'(ld[j]), 32'(qd[j]));
        end
      end
      chk("rand_err", 32'(err), 32'(xerr));
      chk("rand_done", 32'(done), 32'(!xerr));
      chk("rand_cpu_rst", 32'(cpu_rst), 32'(xerr));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
